// File: rtl/sorter_result_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sorter_result_streamer: captures one sorted frame, streams top-K/group.  |
// | Optional perf counters: define SORTER_STREAMER_PERF_CNT_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module sorter_result_streamer #(
  parameter int DATAWIDTH      = 8,
  parameter int MAX_DATALENGTH = 32,
  parameter int MAX_GROUP      = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATAWIDTH*MAX_DATALENGTH-1:0] in_data_i,
  input  logic [5:0]                          in_length_i,
  input  logic [3:0]                          in_group_i,
  input  logic [5:0]                          in_k_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [DATAWIDTH-1:0]                out_data_o,
  output logic [2:0]                          out_group_o,
  output logic [4:0]                          out_rank_o,
  output logic                                out_glast_o,
  output logic                                out_last_o,
  output logic                                frame_done_o,
  output logic                                err_o
`ifdef SORTER_STREAMER_PERF_CNT_EN
  ,
  output logic [15:0]                         beat_cnt_o,
  output logic [15:0]                         frame_cnt_o
`endif
);

  localparam int AW = $clog2(MAX_DATALENGTH);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             g_q, g_d;
  logic [4:0]             r_q, r_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [3:0]             group_q;
  logic [5:0]             s_q, e_q;
  logic [DATAWIDTH-1:0]   elem_q [MAX_DATALENGTH];
  logic                   load;

  logic                   grp_ok, len_ok, frame_bad, frame_empty, accept, fire;
  logic                   r_last, g_last;
  logic [5:0]             div, s_in, rem_in, e_in, idx;

  // Divisor forced to 1 for an illegal group so the divider never sees zero.
  assign grp_ok      = (in_group_i != 4'd0) && (32'(in_group_i) <= 32'(MAX_GROUP));
  assign len_ok      = 32'(in_length_i) <= 32'(MAX_DATALENGTH);
  assign div         = grp_ok ? {2'b00, in_group_i} : 6'd1;
  assign s_in        = in_length_i / div;
  assign rem_in      = in_length_i % div;
  assign frame_bad   = !grp_ok || !len_ok || (rem_in != 6'd0);
  assign frame_empty = (in_length_i == 6'd0);
  assign e_in        = ((in_k_i == 6'd0) || (in_k_i > s_in)) ? s_in : in_k_i;
  assign accept      = in_valid_i && (state_q == IDLE);

  assign in_ready_o   = (state_q == IDLE) && !rst_i;
  assign out_valid_o  = (state_q == STREAM);
  assign fire         = out_valid_o && out_ready_i;
  assign r_last       = ({1'b0, r_q} == (e_q - 6'd1));
  assign g_last       = ({1'b0, g_q} == (group_q - 4'd1));
  assign idx          = ({3'b000, g_q} * s_q) + {1'b0, r_q};
  assign out_data_o   = elem_q[idx[AW-1:0]];
  assign out_group_o  = g_q;
  assign out_rank_o   = r_q;
  assign out_glast_o  = out_valid_o && r_last;
  assign out_last_o   = out_valid_o && r_last && g_last;
  assign frame_done_o = done_q;
  assign err_o        = err_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    r_d     = r_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (frame_bad) begin
            err_d = 1'b1;
          end else if (frame_empty) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = STREAM;
            g_d     = 3'd0;
            r_d     = 5'd0;
          end
        end
      end
      STREAM: begin
        if (fire) begin
          if (r_last) begin
            r_d = 5'd0;
            if (g_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
              g_d     = 3'd0;
            end else begin
              g_d = g_q + 3'd1;
            end
          end else begin
            r_d = r_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= 3'd0;
      r_q     <= 5'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      group_q <= 4'd0;
      s_q     <= 6'd0;
      e_q     <= 6'd0;
      for (int i = 0; i < MAX_DATALENGTH; i++) elem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      r_q     <= r_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (load) begin
        group_q <= in_group_i;
        s_q     <= s_in;
        e_q     <= e_in;
        for (int i = 0; i < MAX_DATALENGTH; i++)
          elem_q[i] <= in_data_i[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

`ifdef SORTER_STREAMER_PERF_CNT_EN
  logic [15:0] beat_cnt_q, frame_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      if (fire && (beat_cnt_q != 16'hFFFF)) beat_cnt_q <= beat_cnt_q + 16'd1;
      if (done_q && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign frame_cnt_o = frame_cnt_q;
`else
  // Counters and their ports are omitted entirely in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_sorter_result_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sorter_result_streamer: randomized self-checking bench.   Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_sorter_result_streamer;

  localparam int DW = 8;
  localparam int ML = 32;
  localparam int MG = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW*ML-1:0] in_data;
  logic [5:0]      in_length;
  logic [3:0]      in_group;
  logic [5:0]      in_k;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_group;
  logic [4:0]      out_rank;
  logic            out_glast;
  logic            out_last;
  logic            frame_done;
  logic            err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int data;
    int grp;
    int rank;
    bit glast;
    bit last;
  } beat_t;

  sorter_result_streamer #(
    .DATAWIDTH      (DW),
    .MAX_DATALENGTH (ML),
    .MAX_GROUP      (MG)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_length_i  (in_length),
    .in_group_i   (in_group),
    .in_k_i       (in_k),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_group_o  (out_group),
    .out_rank_o   (out_rank),
    .out_glast_o  (out_glast),
    .out_last_o   (out_last),
    .frame_done_o (frame_done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; all sampling and driving happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_length = '0;
    in_group  = '0;
    in_k      = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({out_valid, out_data, out_group, out_rank, out_glast, out_last, frame_done, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%0h grp=%0d rank=%0d glast=%b last=%b done=%b err=%b, expected all zero",
               out_valid, out_data, out_group, out_rank, out_glast, out_last, frame_done, err);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_low: got %b expected 0", in_ready);
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_high: got %b expected 1", in_ready);
    end
  endtask

  // Drives one frame and checks every observable cycle against a model built
  // from the frame rules. mode: 0 ready held, 1 ready toggles, 2 ready random.
  task automatic test_frame(input string name, input int len, input int grp, input int k,
                            input int mode, input bit rnd_data);
    int    elems[ML];
    beat_t q[$];
    beat_t b;
    bit    invalid, empty, rdy;
    int    s, e, cyc, nbeat;

    for (int i = 0; i < ML; i++) begin
      elems[i] = rnd_data ? int'($urandom_range(0, 255)) : (31 - i);
      in_data[i*DW +: DW] = DW'(elems[i]);
    end

    invalid = (grp == 0) || (grp > MG) || (len > ML) || ((len % grp) != 0);
    empty   = !invalid && (len == 0);
    if (!invalid && !empty) begin
      s = len / grp;
      e = (k == 0 || k > s) ? s : k;
      for (int g = 0; g < grp; g++)
        for (int r = 0; r < e; r++) begin
          b.data  = elems[g*s + r];
          b.grp   = g;
          b.rank  = r;
          b.glast = (r == e - 1);
          b.last  = (r == e - 1) && (g == grp - 1);
          q.push_back(b);
        end
    end

    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before: got %b expected 1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_length = 6'(len);
    in_group  = 4'(grp);
    in_k      = 6'(k);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;

    if (invalid || empty) begin
      total++;
      if (err !== invalid || frame_done !== empty || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s pulse: got err=%b done=%b valid=%b ready=%b expected err=%b done=%b valid=0 ready=1",
                 name, err, frame_done, out_valid, in_ready, invalid, empty);
      end
      tick();
      total++;
      if (err !== 1'b0 || frame_done !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s pulse_end: got err=%b done=%b valid=%b expected 0 0 0", name, err, frame_done, out_valid);
      end
      return;
    end

    cyc   = 0;
    nbeat = 0;
    while (q.size() > 0 && cyc < 400) begin
      b = q[0];
      total++;
      if (out_valid !== 1'b1 || out_data !== DW'(b.data) || out_group !== 3'(b.grp) ||
          out_rank !== 5'(b.rank) || out_glast !== b.glast || out_last !== b.last) begin
        bad++;
        $display("FAIL %s beat%0d: got valid=%b data=%0d grp=%0d rank=%0d glast=%b last=%b expected valid=1 data=%0d grp=%0d rank=%0d glast=%b last=%b",
                 name, nbeat, out_valid, out_data, out_group, out_rank, out_glast, out_last,
                 b.data, b.grp, b.rank, b.glast, b.last);
      end
      total++;
      if (in_ready !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL %s busy_flags: got ready=%b done=%b err=%b expected 0 0 0", name, in_ready, frame_done, err);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      tick();
      if (rdy) begin
        void'(q.pop_front());
        nbeat++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d beats left expected 0", name, q.size());
      return;
    end
    total++;
    if (frame_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s done: got done=%b valid=%b ready=%b err=%b expected 1 0 1 0",
               name, frame_done, out_valid, in_ready, err);
    end
    tick();
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width: got %b expected 0", name, frame_done);
    end
  endtask

  task automatic test_topk();
    test_frame("topk", 8, 2, 3, 0, 1'b0);
    test_frame("all_one_group", 20, 1, 0, 0, 1'b0);
  endtask

  task automatic test_empty();
    test_frame("empty", 0, 1, 0, 0, 1'b0);
  endtask

  task automatic test_errors();
    test_frame("err_mod", 10, 3, 0, 0, 1'b0);
    test_frame("err_g0", 8, 0, 0, 0, 1'b0);
    test_frame("err_g9", 18, 9, 0, 0, 1'b0);
    test_frame("err_len", 40, 1, 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    test_frame("stall", 32, 8, 2, 1, 1'b0);
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < ML; i++) in_data[i*DW +: DW] = DW'(31 - i);
    in_valid  = 1'b1;
    in_length = 6'd32;
    in_group  = 4'd8;
    in_k      = 6'd2;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd26 || out_group !== 3'd1 || out_rank !== 5'd1) begin
      bad++;
      $display("FAIL abort_beat4: got valid=%b data=%0d grp=%0d rank=%0d expected 1 26 1 1",
               out_valid, out_data, out_group, out_rank);
    end
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got valid=%b done=%b expected 0 0", out_valid, frame_done);
    end
    rst       = 1'b0;
    out_ready = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_after: got valid=%b done=%b ready=%b expected 0 0 1", out_valid, frame_done, in_ready);
    end
    test_frame("after_abort", 32, 8, 2, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_frame("b2b_a", 12, 4, 1, 0, 1'b1);
    test_frame("b2b_b", 6, 2, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    int g, s, len, k;
    for (int n = 0; n < 25; n++) begin
      g   = int'($urandom_range(1, MG));
      s   = int'($urandom_range(0, ML / g));
      len = g * s;
      if ($urandom_range(0, 7) == 0) len = len + 1;
      if (len > 63) len = 63;
      k   = int'($urandom_range(0, s + 2));
      test_frame("random", len, g, k, 2, 1'b1);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_topk();
    test_empty();
    test_errors();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
